fpu_issue_queue: RTL and testbench

//  Issue stage directly upstream of fpu_top: buffers 32-bit RV32F OP-FP/R4 instructions from the core,

---
 rtl/fpu_issue_queue_if.sv | 23 ++
 rtl/fpu_issue_queue.sv | 129 ++++++++++++
 tb/tb_fpu_issue_queue.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_queue_if.sv
// Core-to-issue-queue handshake plus the issue-side outputs that feed fpu_top.
interface fpu_issue_queue_if #(
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_instr;
  logic                     flush;
  logic [31:0]              fpu_instr;
  logic                     fpu_valid;
  logic [$clog2(DEPTH):0]   queue_count;
  logic [15:0]              stall_count;

  modport master (
    output in_valid, in_instr, flush,
    input  in_ready, fpu_instr, fpu_valid, queue_count, stall_count
  );

  modport slave (
    input  in_valid, in_instr, flush,
    output in_ready, fpu_instr, fpu_valid, queue_count, stall_count
  );
endinterface

// File: rtl/fpu_issue_queue.sv
// In-order issue FIFO with a LAT-deep RAW scoreboard in front of fpu_top; one instr or bubble per cycle.
// Define FPU_ISSUE_PERF_EN to build the saturating hazard-stall counter.
module fpu_issue_queue #(
  parameter int          DEPTH       = 4,
  parameter int          LAT         = 4,
  parameter logic [31:0] BUBBLE_INSN = 32'h0000_0053
) (
  input  logic             clk,
  input  logic             rst_n,
  fpu_issue_queue_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
  } sb_ent_t;

  logic [DEPTH-1:0][31:0] mem_q;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  sb_ent_t [LAT-1:0]      sb_q, sb_d;
  logic [31:0]            fpu_instr_q, fpu_instr_d;
  logic                   fpu_valid_q, fpu_valid_d;

  logic                   empty, push, pop, hazard;
  logic [31:0]            head;
  logic                   use12, use3;
  logic [4:0]             rs1, rs2, rs3;
  logic [LAT-1:0]         hit;

  assign empty        = (cnt_q == '0);
  assign bus.in_ready = (cnt_q < CW'(DEPTH));
  assign head         = mem_q[rd_ptr_q];

  // R4 (opcode[6:4]=100) reads rs1..rs3; OP-FP reads rs1/rs2, FSQRT's rs2 included conservatively
  assign use3  = (head[6:4] == 3'b100);
  assign use12 = use3 || (head[6:2] == 5'b10100);
  assign rs1   = head[19:15];
  assign rs2   = head[24:20];
  assign rs3   = head[31:27];

  for (genvar i = 0; i < LAT; i++) begin : g_sb
    assign hit[i] = sb_q[i].vld &&
                    ((use12 && ((rs1 == sb_q[i].rd) || (rs2 == sb_q[i].rd))) ||
                     (use3  &&  (rs3 == sb_q[i].rd)));
  end

  assign hazard = |hit;
  assign pop    = !empty && !hazard && !bus.flush;
  assign push   = bus.in_valid && bus.in_ready && !bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Scoreboard keeps shifting through a flush: in-flight writes still land in the regfile
  always_comb begin
    sb_d = sb_q;
    for (int i = 1; i < LAT; i++) sb_d[i] = sb_q[i-1];
    sb_d[0].vld = pop;
    sb_d[0].rd  = head[11:7];
  end

  always_comb begin
    fpu_valid_d = pop;
    fpu_instr_d = pop ? head : BUBBLE_INSN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      sb_q        <= '0;
      fpu_instr_q <= BUBBLE_INSN;
      fpu_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      sb_q        <= sb_d;
      fpu_instr_q <= fpu_instr_d;
      fpu_valid_q <= fpu_valid_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt_q
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_instr;
  end

  assign bus.fpu_instr   = fpu_instr_q;
  assign bus.fpu_valid   = fpu_valid_q;
  assign bus.queue_count = cnt_q;

`ifdef FPU_ISSUE_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (!empty && hazard && !bus.flush && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign bus.stall_count = stall_q;
`else
  assign bus.stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed bench for fpu_issue_queue: queue/time-based reference model checked every cycle plus literal pins.
module tb_fpu_issue_queue;
  localparam int          DEPTH = 4;
  localparam int          LAT   = 4;
  localparam logic [31:0] BUB   = 32'h0000_0053;
  localparam logic [6:0]  F_ADD = 7'h00, F_SUB = 7'h04, F_MUL = 7'h08;
`ifdef FPU_ISSUE_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpu_issue_queue_if #(.DEPTH(DEPTH)) bus();

  fpu_issue_queue #(.DEPTH(DEPTH), .LAT(LAT), .BUBBLE_INSN(BUB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] opfp(input logic [6:0] f7, input int rd, input int rs1, input int rs2);
    return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h53};
  endfunction

  function automatic logic [31:0] fmadd(input int rd, input int rs1, input int rs2, input int rs3);
    return {5'(rs3), 2'b00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h43};
  endfunction

  // Reference model: a register written by an issue at edge k is readable from edge k+LAT+1 on.
  logic [31:0] mq[$];
  int          last_iss[32];
  int          mcyc = 0;
  logic        m_valid;
  logic [31:0] m_instr;
  int          m_stall;
  logic [31:0] m_h;
  bit          m_rdy, m_hz, m_iss;

  function automatic bit m_haz(input logic [31:0] h);
    bit r4 = (h[6:2] inside {5'b10000, 5'b10001, 5'b10010, 5'b10011});
    bit fp = r4 || (h[6:2] == 5'b10100);
    bit hz = 1'b0;
    if (fp && (mcyc - last_iss[h[19:15]] <= LAT)) hz = 1'b1;
    if (fp && (mcyc - last_iss[h[24:20]] <= LAT)) hz = 1'b1;
    if (r4 && (mcyc - last_iss[h[31:27]] <= LAT)) hz = 1'b1;
    return hz;
  endfunction

  function automatic logic [31:0] exp_stall();
    return (PERF != 0) ? 32'(m_stall) : 32'h0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      foreach (last_iss[r]) last_iss[r] = -1000;
      m_valid = 1'b0;
      m_instr = BUB;
      m_stall = 0;
    end else begin
      mcyc++;
      m_rdy = (mq.size() < DEPTH);
      m_hz  = 1'b0;
      m_iss = 1'b0;
      m_h   = BUB;
      if (mq.size() > 0) begin
        m_h   = mq[0];
        m_hz  = m_haz(m_h);
        m_iss = !m_hz && !bus.flush;
      end
      if ((mq.size() > 0) && m_hz && !bus.flush && (m_stall < 65535)) m_stall++;
      if (bus.flush) mq.delete();
      else begin
        if (m_iss) begin
          void'(mq.pop_front());
          last_iss[m_h[11:7]] = mcyc;
        end
        if (bus.in_valid && m_rdy) mq.push_back(bus.in_instr);
      end
      m_valid = m_iss;
      m_instr = m_iss ? m_h : BUB;
    end
  end

  typedef struct {
    int          cyc;
    logic [31:0] ins;
    logic [15:0] st;
  } iss_t;
  iss_t log_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_valid", 32'(bus.fpu_valid),   32'(m_valid));
      chk("cyc_instr", bus.fpu_instr,        m_instr);
      chk("cyc_count", 32'(bus.queue_count), 32'(mq.size()));
      chk("cyc_ready", 32'(bus.in_ready),    32'(mq.size() < DEPTH));
      chk("cyc_stall", 32'(bus.stall_count), exp_stall());
      if (bus.fpu_valid) log_q.push_back('{mcyc, bus.fpu_instr, bus.stall_count});
    end
  end

  task automatic send(input logic [31:0] ins, output int pc, output int waits);
    int w = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("send_timeout", 32'(w), 32'h0);
    @(posedge clk);
    #1;
    pc    = mcyc;
    waits = w;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] a, b, c, d, e, f, p, n4;
  int pc, pa, w;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.flush    = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_valid", 32'(bus.fpu_valid),   32'h0);
    chk("rst_instr", bus.fpu_instr,        BUB);
    chk("rst_count", 32'(bus.queue_count), 32'h0);
    chk("rst_ready", 32'(bus.in_ready),    32'h1);
    chk("rst_stall", 32'(bus.stall_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // independent stream: one issue per cycle
    log_q.delete();
    a = opfp(F_ADD, 1, 2, 3);
    b = opfp(F_MUL, 4, 5, 6);
    c = opfp(F_SUB, 7, 8, 9);
    send(a, pa, w);
    send(b, pc, w);
    send(c, pc, w);
    idle(10);
    chk("t2_issued", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      chk("t2_order0", log_q[0].ins, a);
      chk("t2_order2", log_q[2].ins, c);
      chk("t2_latency", 32'(log_q[0].cyc - pa), 32'd1);
      chk("t2_gap01",   32'(log_q[1].cyc - log_q[0].cyc), 32'd1);
      chk("t2_gap12",   32'(log_q[2].cyc - log_q[1].cyc), 32'd1);
    end

    // RAW through rs1 then rs3: LAT bubbles each
    do_reset();
    log_q.delete();
    a = opfp(F_ADD, 1, 2, 3);
    b = opfp(F_MUL, 4, 1, 5);
    c = fmadd(6, 7, 8, 4);
    send(a, pc, w);
    send(b, pc, w);
    send(c, pc, w);
    idle(16);
    chk("t3_issued", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      chk("t3_gap_rs1", 32'(log_q[1].cyc - log_q[0].cyc), 32'd5);
      chk("t3_gap_rs3", 32'(log_q[2].cyc - log_q[1].cyc), 32'd5);
      chk("t3_stall_b", 32'(log_q[1].st), (PERF != 0) ? 32'd4 : 32'd0);
      chk("t3_stall_c", 32'(log_q[2].st), (PERF != 0) ? 32'd8 : 32'd0);
    end
    chk("t3_stall_end", 32'(bus.stall_count), (PERF != 0) ? 32'd8 : 32'd0);

    // fill behind a hazarded head
    do_reset();
    log_q.delete();
    send(opfp(F_ADD, 1, 2, 3),    pc, w);
    send(opfp(F_MUL, 4, 1, 5),    pc, w);
    send(opfp(F_SUB, 10, 11, 12), pc, w);
    send(opfp(F_ADD, 13, 14, 15), pc, w);
    send(opfp(F_MUL, 16, 17, 18), pc, w);
    chk("t4_full_count", 32'(bus.queue_count), 32'd4);
    chk("t4_full_ready", 32'(bus.in_ready),    32'd0);
    n4 = opfp(F_SUB, 19, 20, 21);
    send(n4, pc, w);
    chk("t4_wait_cycles", 32'(w), 32'd2);
    chk("t4_pushpop_count", 32'(bus.queue_count), 32'd3);
    idle(10);
    chk("t4_issued", 32'(log_q.size()), 32'd6);
    if (log_q.size() == 6) chk("t4_last", log_q[5].ins, n4);

    // flush drops queue but not in-flight scoreboard
    do_reset();
    log_q.delete();
    p = opfp(F_ADD, 20, 2, 3);
    a = opfp(F_ADD, 1, 20, 3);
    b = opfp(F_MUL, 4, 1, 5);
    c = opfp(F_SUB, 10, 11, 12);
    d = opfp(F_ADD, 13, 14, 15);
    f = opfp(F_MUL, 22, 23, 24);
    e = opfp(F_SUB, 9, 1, 2);
    send(p, pc, w);
    send(a, pc, w);
    send(b, pc, w);
    send(c, pc, w);
    send(d, pc, w);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_pre_count", 32'(bus.queue_count), 32'd3);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = f;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("t5_flush_count", 32'(bus.queue_count), 32'd0);
    chk("t5_flush_valid", 32'(bus.fpu_valid),   32'd0);
    bus.in_instr = e;
    @(negedge clk);
    bus.in_valid = 1'b0;
    idle(10);
    chk("t5_issued", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      chk("t5_a", log_q[1].ins, a);
      chk("t5_e", log_q[2].ins, e);
      chk("t5_sb_kept", 32'(log_q[2].cyc - log_q[1].cyc), 32'd5);
    end

    // non-FP opcode bypasses the hazard check
    do_reset();
    log_q.delete();
    send(opfp(F_ADD, 0, 1, 2), pc, w);
    send(32'h0000_0013, pc, w);
    idle(8);
    chk("t6_issued", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("t6_ins", log_q[1].ins, 32'h0000_0013);
      chk("t6_gap", 32'(log_q[1].cyc - log_q[0].cyc), 32'd1);
    end

    // async reset in the middle of traffic
    send(opfp(F_ADD, 1, 2, 3), pc, w);
    send(opfp(F_MUL, 4, 1, 5), pc, w);
    chk("t1_pre_valid", 32'(bus.fpu_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_valid", 32'(bus.fpu_valid),   32'h0);
    chk("t1_instr", bus.fpu_instr,        BUB);
    chk("t1_count", 32'(bus.queue_count), 32'h0);
    chk("t1_ready", 32'(bus.in_ready),    32'h1);
    chk("t1_stall", 32'(bus.stall_count), 32'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
